led_frame_ctrl: RTL and testbench



---
 rtl/led_frame_ctrl.sv | 170 +++++++++++++++++
 tb/tb_led_frame_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_ctrl.sv
// 4x4 LED matrix frame controller: two-port round-robin writes into a back buffer,
// frame-synchronous commit to a front buffer, and row scan with dead time and per-column PWM.
module led_frame_ctrl #(
  parameter int unsigned PRESCALE    = 16,
  parameter int unsigned DEAD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       wr0_valid,
  input  logic [3:0] wr0_addr,
  input  logic [7:0] wr0_data,
  output logic       wr0_ready,
  input  logic       wr1_valid,
  input  logic [3:0] wr1_addr,
  input  logic [7:0] wr1_data,
  output logic       wr1_ready,
  input  logic       commit,
  output logic       commit_pending,
  output logic       frame_start,
  output logic [3:0] aled,
  output logic [3:0] kled_tri
);

  localparam int unsigned CMAX = (PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] PS_LAST   = CW'(PRESCALE - 1);

  // S_PARK is row 0 dead time held at frame start; leaving it is a frame boundary.
  typedef enum logic [1:0] {
    S_PARK,
    S_DEAD,
    S_ON
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    step_q, step_d;
  logic          boundary;

  logic [7:0] front_q [16];
  logic [7:0] front_d [16];
  logic [7:0] back_q  [16];
  logic [7:0] back_d  [16];

  logic       rr_q, rr_d;
  logic       pend_q, pend_d;
  logic       fs_q, fs_d;
  logic [3:0] aled_q, aled_d;
  logic [3:0] kled_q, kled_d;
  logic       gnt0, gnt1, copy;

  // Scan sequencer.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    boundary = 1'b0;
    if (!enable) begin
      state_d  = S_PARK;
      row_d    = '0;
      cnt_d    = '0;
      step_d   = '0;
      boundary = 1'b1;
    end else begin
      unique case (state_q)
        S_PARK: begin
          state_d  = S_DEAD;
          row_d    = '0;
          cnt_d    = '0;
          step_d   = '0;
          boundary = 1'b1;
        end
        S_DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = S_ON;
            cnt_d   = '0;
            step_d  = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_ON: begin
          if (cnt_q == PS_LAST) begin
            cnt_d = '0;
            if (step_q == 8'hFF) begin
              state_d  = S_DEAD;
              row_d    = row_q + 2'd1;
              step_d   = '0;
              boundary = (row_q == 2'd3);
            end else begin
              step_d = step_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_PARK;
      endcase
    end
  end

  // Matrix drive, registered from the current scan position.
  always_comb begin
    aled_d = '0;
    kled_d = '0;
    if (state_q == S_ON) begin
      aled_d[row_q] = 1'b1;
      for (int unsigned c = 0; c < 4; c++) begin
        kled_d[c] = step_q < front_q[{row_q, 2'(c)}];
      end
    end
    fs_d = boundary & enable;
  end

  // Arbiter, commit and buffers.
  always_comb begin
    gnt0   = wr0_valid & (~wr1_valid | ~rr_q);
    gnt1   = wr1_valid & (~wr0_valid | rr_q);
    rr_d   = rr_q;
    if (gnt0) rr_d = 1'b1;
    if (gnt1) rr_d = 1'b0;
    copy   = boundary & (pend_q | commit);
    pend_d = copy ? 1'b0 : (pend_q | commit);
    back_d = back_q;
    if (gnt0) back_d[wr0_addr] = wr0_data;
    if (gnt1) back_d[wr1_addr] = wr1_data;
    // Copy from back_q so a same-cycle write reaches only the back buffer.
    front_d = copy ? back_q : front_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_PARK;
      row_q   <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      rr_q    <= 1'b0;
      pend_q  <= 1'b0;
      fs_q    <= 1'b0;
      aled_q  <= '0;
      kled_q  <= '0;
      front_q <= '{default: '0};
      back_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      fs_q    <= fs_d;
      aled_q  <= aled_d;
      kled_q  <= kled_d;
      front_q <= front_d;
      back_q  <= back_d;
    end
  end

  assign wr0_ready      = gnt0;
  assign wr1_ready      = gnt1;
  assign commit_pending = pend_q;
  assign frame_start    = fs_q;
  assign aled           = aled_q;
  assign kled_tri       = kled_q;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Randomised scoreboard bench for led_frame_ctrl: a frame-position model predicts every
// output cycle and port grant; a negedge monitor pops and compares.
module tb_led_frame_ctrl;

  localparam int PS    = 1;
  localparam int DC    = 2;
  localparam int SEG   = DC + 256 * PS;
  localparam int FRAME = 4 * SEG;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       wr0_valid, wr1_valid;
  logic [3:0] wr0_addr, wr1_addr;
  logic [7:0] wr0_data, wr1_data;
  logic       wr0_ready, wr1_ready;
  logic       commit;
  logic       commit_pending, frame_start;
  logic [3:0] aled, kled_tri;

  always #5 clk = ~clk;

  led_frame_ctrl #(.PRESCALE(PS), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .wr0_valid(wr0_valid), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
    .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
    .commit(commit), .commit_pending(commit_pending), .frame_start(frame_start),
    .aled(aled), .kled_tri(kled_tri)
  );

  typedef struct packed {
    logic [3:0] aled;
    logic [3:0] kled;
    logic       fs;
    logic       pend;
  } obs_t;

  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q[$];

  // Reference model: frame position (0..FRAME-1) or parked, plus the two buffers.
  logic [7:0] m_back [16];
  logic [7:0] m_front[16];
  bit         m_pend, m_parked, m_rr;
  int         m_pos;

  function automatic logic [1:0] exp_grant(bit v0, bit v1, bit rr);
    if (v0 && v1) return rr ? 2'b10 : 2'b01;
    return {v1, v0};
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit         bnd, cp;
    logic [1:0] g;
    obs_t       e;
    int         row, off;
    if (!rst) begin
      m_back   = '{default: 8'd0};
      m_front  = '{default: 8'd0};
      m_pend   = 0;
      m_parked = 1;
      m_rr     = 0;
      m_pos    = 0;
      exp_q.delete();
    end else begin
      bnd = !enable || m_parked || (m_pos == FRAME - 1);
      e   = '0;
      if (!m_parked) begin
        row = m_pos / SEG;
        off = m_pos % SEG;
        if (off >= DC) begin
          e.aled = 4'(1 << row);
          for (int c = 0; c < 4; c++)
            e.kled[c] = ((off - DC) / PS) < int'(m_front[4 * row + c]);
        end
      end
      e.fs   = bnd && enable;
      cp     = bnd && (m_pend || commit);
      e.pend = cp ? 1'b0 : (m_pend || commit);
      exp_q.push_back(e);
      g = exp_grant(wr0_valid, wr1_valid, m_rr);
      if (cp) m_front = m_back;
      if (g[0]) begin m_back[wr0_addr] = wr0_data; m_rr = 1; end
      if (g[1]) begin m_back[wr1_addr] = wr1_data; m_rr = 0; end
      m_pend = e.pend;
      if (!enable) begin
        m_parked = 1;
        m_pos    = 0;
      end else if (m_parked) begin
        m_parked = 0;
        m_pos    = 0;
      end else begin
        m_pos = (m_pos == FRAME - 1) ? 0 : m_pos + 1;
      end
    end
  end

  // Monitor.
  int since = 0;
  bit have_prev = 0;
  always @(negedge clk) begin : monitor
    obs_t       e, a;
    logic [1:0] eg;
    if (!rst) begin
      have_prev = 0;
      since     = 0;
    end else begin
      eg = exp_grant(wr0_valid, wr1_valid, m_rr);
      checks++;
      if ({wr1_ready, wr0_ready} !== eg) begin
        failures++;
        $display("FAIL ready t=%0t actual=%b required=%b", $time, {wr1_ready, wr0_ready}, eg);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.aled = aled; a.kled = kled_tri; a.fs = frame_start; a.pend = commit_pending;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs t=%0t actual aled=%b kled=%b fs=%b pend=%b required aled=%b kled=%b fs=%b pend=%b",
                   $time, a.aled, a.kled, a.fs, a.pend, e.aled, e.kled, e.fs, e.pend);
        end
      end
      if (!enable) have_prev = 0;
      since++;
      if (frame_start) begin
        if (have_prev) begin
          checks++;
          if (since != FRAME) begin
            failures++;
            $display("FAIL frame_period t=%0t actual=%0d required=%0d", $time, since, FRAME);
          end
        end
        have_prev = enable;
        since     = 0;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(bit port, logic [3:0] a, logic [7:0] d);
    bit g = 0;
    if (port) begin wr1_valid = 1; wr1_addr = a; wr1_data = d; end
    else      begin wr0_valid = 1; wr0_addr = a; wr0_data = d; end
    for (int i = 0; i < 16 && !g; i++) begin
      @(negedge clk);
      g = port ? wr1_ready : wr0_ready;
      @(posedge clk);
      #1;
    end
    wr0_valid = 0;
    wr1_valid = 0;
    checks++;
    if (!g) begin
      failures++;
      $display("FAIL write_grant_timeout port=%0d actual=0 required=1", port);
    end
  endtask

  task automatic pulse_commit();
    commit = 1;
    tick(1);
    commit = 0;
  endtask

  task automatic wait_pos(int p);
    int n = 0;
    while (!(m_pos == p && !m_parked) && n < 2 * FRAME + 4) begin
      tick(1);
      n++;
    end
    checks++;
    if (!(m_pos == p && !m_parked)) begin
      failures++;
      $display("FAIL wait_pos_timeout actual=%0d required=%0d", m_pos, p);
    end
  endtask

  task automatic check_dark(string name);
    checks++;
    if ({aled, kled_tri, frame_start} !== 9'b0) begin
      failures++;
      $display("FAIL %s actual aled=%b kled=%b fs=%b required 0", name, aled, kled_tri, frame_start);
    end
  endtask

  initial begin
    int low_left;
    rst = 0; enable = 1; commit = 0;
    wr0_valid = 0; wr0_addr = 0; wr0_data = 0;
    wr1_valid = 0; wr1_addr = 0; wr1_data = 0;
    #22;
    check_dark("reset_state");
    checks++;
    if (commit_pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_pending actual=%b required=0", commit_pending);
    end
    @(negedge clk);
    rst = 1;
    tick(FRAME + 50);

    wr(0, 4'd5, 8'd128);
    pulse_commit();
    tick(2 * FRAME);

    wr0_valid = 1; wr1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wr0_addr = 4'($urandom); wr0_data = 8'($urandom);
      wr1_addr = 4'($urandom); wr1_data = 8'($urandom);
      tick(1);
    end
    wr0_valid = 0;
    tick(3);
    wr1_valid = 0;

    wr(0, 4'd0, 8'd255);
    tick(3 * FRAME);
    pulse_commit();
    tick(2 * FRAME);

    wr(1, 4'd0, 8'd200);
    wait_pos(FRAME - 1);
    commit = 1; wr0_valid = 1; wr0_addr = 4'd0; wr0_data = 8'd7;
    tick(1);
    commit = 0; wr0_valid = 0;
    tick(FRAME + 10);
    pulse_commit();
    tick(2 * FRAME);

    low_left = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      wr0_valid = 1'($urandom_range(0, 1)); wr0_addr = 4'($urandom); wr0_data = 8'($urandom);
      wr1_valid = 1'($urandom_range(0, 1)); wr1_addr = 4'($urandom); wr1_data = 8'($urandom);
      commit    = ($urandom_range(0, 399) == 0);
      if (low_left > 0) low_left--;
      else if ($urandom_range(0, 1499) == 0) low_left = $urandom_range(1, 20);
      enable = (low_left == 0);
      tick(1);
    end
    wr0_valid = 0; wr1_valid = 0; commit = 0; enable = 1;
    tick(FRAME + 10);

    wait_pos(2 * SEG + DC + 100);
    #2 rst = 0;
    #1 check_dark("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    tick(FRAME + FRAME / 2);

    wr(0, 4'd6, 8'd90);
    pulse_commit();
    tick(FRAME + 10);
    wait_pos(SEG + DC + 10);
    enable = 0;
    tick(2);
    check_dark("enable_low");
    tick(20);
    enable = 1;
    tick(FRAME + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
